// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch port and the data port of the pipeline. A four-state FSM
// (IDLE, ISSUE, WAIT, DONE) sequences each access, captures read data and
// issues a one-cycle ready pulse to the owning port.
// A pending request from the other port is granted at the read-data capture
// edge, so alternating ports overlap the ready pulse with the next m_en.
// Optional build macro ARB_ROUND_ROBIN_EN: on a simultaneous request the port
// that did not own the previous grant wins (default: data port always wins).
module mem_port_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          d_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int   CW    = $clog2(LAT + 1);
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic            owner_r, owner_s;
    logic            squash_r, squash_s, squash_hold_s;
    logic            op_we_r, op_we_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            grant_s, grant_who_s, win_s;
    logic            m_en_s, m_we_s, i_ready_s, d_ready_s;
    logic [AW-1:0]   m_addr_s;
    logic [DW-1:0]   m_wdata_s, i_rdata_s, d_rdata_s;
    logic            i_elig_s, d_elig_s, fetch_owned_s, other_elig_s;

    // A flushed fetch may not compete; the non-owner is the only candidate
    // once an access is completing.
    assign i_elig_s      = i_req & ~i_flush;
    assign d_elig_s      = d_req;
    assign fetch_owned_s = (owner_r == OWN_I);
    assign other_elig_s  = fetch_owned_s ? d_elig_s : i_elig_s;

    assign i_stall = i_req & ~i_ready;
    assign d_stall = d_req & ~d_ready;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_r;

    // Round-robin winner selection for an IDLE arbitration cycle.
    always_comb begin
        if (d_elig_s & i_elig_s) begin
            win_s = (last_owner_r == OWN_D) ? OWN_I : OWN_D;
        end else if (d_elig_s) begin
            win_s = OWN_D;
        end else begin
            win_s = OWN_I;
        end
    end

    // Remember the port of the most recent grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_owner_r <= OWN_D;
        end else if (grant_s) begin
            last_owner_r <= grant_who_s;
        end else begin
            last_owner_r <= last_owner_r;
        end
    end
`else
    // Fixed-priority winner selection: data port beats fetch.
    always_comb begin
        if (d_elig_s) begin
            win_s = OWN_D;
        end else begin
            win_s = OWN_I;
        end
    end
`endif

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        grant_s       = 1'b0;
        grant_who_s   = owner_r;
        i_ready_s     = 1'b0;
        d_ready_s     = 1'b0;
        i_rdata_s     = i_rdata;
        d_rdata_s     = d_rdata;
        squash_hold_s = squash_r;
        case (state_r)
            IDLE: begin
                if (d_elig_s | i_elig_s) begin
                    grant_s     = 1'b1;
                    grant_who_s = win_s;
                    state_s     = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s         = CW'(LAT - 1);
                state_s       = WAIT;
                squash_hold_s = squash_r | (fetch_owned_s & i_flush);
            end
            WAIT: begin
                squash_hold_s = squash_r | (fetch_owned_s & i_flush);
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s   = cnt_r - CW'(1);
                    state_s = WAIT;
                end else if (squash_hold_s) begin
                    // Squashed fetch: memory access finishes, result dropped.
                    state_s = IDLE;
                end else begin
                    if (fetch_owned_s) begin
                        i_ready_s = 1'b1;
                        i_rdata_s = m_rdata;
                    end else begin
                        d_ready_s = 1'b1;
                        d_rdata_s = op_we_r ? d_rdata : m_rdata;
                    end
                    if (other_elig_s) begin
                        grant_s     = 1'b1;
                        grant_who_s = ~owner_r;
                        state_s     = ISSUE;
                    end else begin
                        state_s = DONE;
                    end
                end
            end
            DONE: begin
                // The owner's request is the one being completed: ignore it.
                if (other_elig_s) begin
                    grant_s     = 1'b1;
                    grant_who_s = ~owner_r;
                    state_s     = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        owner_s   = grant_s ? grant_who_s : owner_r;
        squash_s  = grant_s ? 1'b0 : squash_hold_s;
        m_en_s    = grant_s;
        m_we_s    = grant_s & (grant_who_s == OWN_D) & d_we;
        op_we_s   = grant_s ? m_we_s : op_we_r;
        m_addr_s  = grant_s ? ((grant_who_s == OWN_D) ? d_addr : i_addr) : m_addr;
        m_wdata_s = (grant_s & (grant_who_s == OWN_D)) ? d_wdata : m_wdata;
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= IDLE;
            owner_r  <= OWN_D;
            squash_r <= 1'b0;
            op_we_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= {AW{1'b0}};
            m_wdata  <= {DW{1'b0}};
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
            i_rdata  <= {DW{1'b0}};
            d_rdata  <= {DW{1'b0}};
        end else begin
            state_r  <= state_s;
            owner_r  <= owner_s;
            squash_r <= squash_s;
            op_we_r  <= op_we_s;
            cnt_r    <= cnt_s;
            m_en     <= m_en_s;
            m_we     <= m_we_s;
            m_addr   <= m_addr_s;
            m_wdata  <= m_wdata_s;
            i_ready  <= i_ready_s;
            d_ready  <= d_ready_s;
            i_rdata  <= i_rdata_s;
            d_rdata  <= d_rdata_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// LAT=2 instance plus hand-written sequences for mid-transaction reset and
// a LAT=1 instance.
module tb_mem_port_arbiter;

    localparam logic [31:0] Z     = 32'h0000_0000;
    localparam logic [31:0] W04   = 32'h8C01_0000;
    localparam logic [31:0] W10   = 32'h1111_0010;
    localparam logic [31:0] W20   = 32'h1234_5678;
    localparam logic [31:0] W30   = 32'h3030_3030;
    localparam logic [31:0] WBEEF = 32'hDEAD_BEEF;
    localparam logic [31:0] JUNK  = 32'hBAD0_BAD0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [7:0]  i_addr = 8'h00, d_addr = 8'h00;
    logic [31:0] d_wdata = 32'h0;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic        i_ready, i_stall, d_ready, d_stall, m_en, m_we;
    logic [7:0]  m_addr;

    logic        i_req1 = 1'b0, d_req1 = 1'b0;
    logic [7:0]  i_addr1 = 8'h00, d_addr1 = 8'h00;
    logic [31:0] i_rdata1, d_rdata1, m_wdata1, m_rdata1;
    logic        i_ready1, i_stall1, d_ready1, d_stall1, m_en1, m_we1;
    logic [7:0]  m_addr1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.AW(8), .DW(32), .LAT(2)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata),
        .i_ready(i_ready), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.AW(8), .DW(32), .LAT(1)) dut_lat1 (
        .clock(clock), .reset(reset),
        .i_req(i_req1), .i_addr(i_addr1), .i_flush(1'b0), .i_rdata(i_rdata1),
        .i_ready(i_ready1), .i_stall(i_stall1),
        .d_req(d_req1), .d_we(1'b0), .d_addr(d_addr1), .d_wdata(32'h0),
        .d_rdata(d_rdata1), .d_ready(d_ready1), .d_stall(d_stall1),
        .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1), .m_rdata(m_rdata1)
    );

    // LAT=2 memory model: read data appears two cycles after the m_en cycle.
    logic [31:0] mem [0:255];
    logic [31:0] pipe0, pipe1;
    always @(posedge clock) begin
        if (!reset) begin
            mem[8'h04] <= W04; mem[8'h08] <= Z; mem[8'h10] <= W10;
            mem[8'h20] <= W20; mem[8'h30] <= W30;
        end else if (m_en && m_we) begin
            mem[m_addr] <= m_wdata;
        end
        pipe0 <= (m_en && !m_we) ? mem[m_addr] : JUNK;
        pipe1 <= pipe0;
    end
    assign m_rdata = pipe1;

    // LAT=1 memory model: word content is a tag plus its address.
    always @(posedge clock) begin
        m_rdata1 <= (m_en1 && !m_we1) ? {24'hC0DE00, m_addr1} : JUNK;
    end

    typedef struct {
        logic ir; logic [7:0] ia; logic fl; logic dr; logic dw; logic [7:0] da; logic [31:0] dd;
        logic en; logic we; logic [7:0] ma; logic [31:0] mw;
        logic iry; logic [31:0] ird; logic drdy; logic [31:0] drd; logic ist; logic dst;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic ir, input logic [7:0] ia, input logic fl, input logic dr,
                       input logic dw, input logic [7:0] da, input logic [31:0] dd,
                       input logic en, input logic we, input logic [7:0] ma, input logic [31:0] mw,
                       input logic iry, input logic [31:0] ird, input logic drdy,
                       input logic [31:0] drd, input logic ist, input logic dst);
        vec_t v;
        v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.en = en; v.we = we; v.ma = ma; v.mw = mw; v.iry = iry; v.ird = ird;
        v.drdy = drdy; v.drd = drd; v.ist = ist; v.dst = dst;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] act_bundle();
        return {18'h0, m_en, m_we, (m_en ? m_addr : 8'h00), ((m_en && m_we) ? m_wdata : Z),
                i_ready, i_rdata, d_ready, d_rdata, i_stall, d_stall};
    endfunction

    function automatic logic [127:0] exp_bundle(input vec_t v);
        return {18'h0, v.en, v.we, (v.en ? v.ma : 8'h00), ((v.en && v.we) ? v.mw : Z),
                v.iry, v.ird, v.drdy, v.drd, v.ist, v.dst};
    endfunction

    initial begin
        logic        bad;
        logic        got_ready;
        logic [4:0]  rdy_hist;
        logic [31:0] rdata_c3;
        logic [7:0]  exp_addr;
        logic        stop, prev_rdy;
        int          en_cnt, rdy_cnt;

        //  ir  ia     fl dr dw da     dd      en we ma     mw     iry ird  drdy drd    ist dst
        // fetch 0x04, uncontended
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, Z,   0, Z,     1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     1, 0, 8'h04, Z,     0, Z,   0, Z,     1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, Z,   0, Z,     1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, Z,   0, Z,     1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     1, W04, 0, Z,     0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W04, 0, Z,     0, 0);
        // fetch 0x10 and load 0x20 together: data first, fetch overlapped
        add(1, 8'h10, 0, 1, 0, 8'h20, Z,     0, 0, 8'h00, Z,     0, W04, 0, Z,     1, 1);
        add(1, 8'h10, 0, 1, 0, 8'h20, Z,     1, 0, 8'h20, Z,     0, W04, 0, Z,     1, 1);
        add(1, 8'h10, 0, 1, 0, 8'h20, Z,     0, 0, 8'h00, Z,     0, W04, 0, Z,     1, 1);
        add(1, 8'h10, 0, 1, 0, 8'h20, Z,     0, 0, 8'h00, Z,     0, W04, 0, Z,     1, 1);
        add(1, 8'h10, 0, 1, 0, 8'h20, Z,     1, 0, 8'h10, Z,     0, W04, 1, W20,   1, 0);
        add(1, 8'h10, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W04, 0, W20,   1, 0);
        add(1, 8'h10, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W04, 0, W20,   1, 0);
        add(1, 8'h10, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     1, W10, 0, W20,   0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 0);
        // store 0xDEADBEEF to 0x08; d_rdata holds
        add(0, 8'h00, 0, 1, 1, 8'h08, WBEEF, 0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 1, 8'h08, WBEEF, 1, 1, 8'h08, WBEEF, 0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 1, 8'h08, WBEEF, 0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 1, 8'h08, WBEEF, 0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 1, 8'h08, WBEEF, 0, 0, 8'h00, Z,     0, W10, 1, W20,   0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 0);
        // load back 0x08; i_flush must not disturb a data access
        add(0, 8'h00, 0, 1, 0, 8'h08, Z,     0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 0, 8'h08, Z,     1, 0, 8'h08, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 1, 1, 0, 8'h08, Z,     0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 0, 8'h08, Z,     0, 0, 8'h00, Z,     0, W10, 0, W20,   0, 1);
        add(0, 8'h00, 0, 1, 0, 8'h08, Z,     0, 0, 8'h00, Z,     0, W10, 1, WBEEF, 0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 0, 0);
        // fetch squashed in WAIT, then a new fetch at 0x30
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     1, 0, 8'h04, Z,     0, W10, 0, WBEEF, 1, 0);
        add(1, 8'h04, 1, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 1, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 0, 0);
        add(1, 8'h30, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 1, 0);
        add(1, 8'h30, 0, 0, 0, 8'h00, Z,     1, 0, 8'h30, Z,     0, W10, 0, WBEEF, 1, 0);
        add(1, 8'h30, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 1, 0);
        add(1, 8'h30, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W10, 0, WBEEF, 1, 0);
        add(1, 8'h30, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     1, W30, 0, WBEEF, 0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W30, 0, WBEEF, 0, 0);
        // flush in IDLE blocks the grant; flush in the fetch's DONE keeps i_ready
        add(1, 8'h04, 1, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W30, 0, WBEEF, 1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W30, 0, WBEEF, 1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     1, 0, 8'h04, Z,     0, W30, 0, WBEEF, 1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W30, 0, WBEEF, 1, 0);
        add(1, 8'h04, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W30, 0, WBEEF, 1, 0);
        add(1, 8'h04, 1, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     1, W04, 0, WBEEF, 0, 0);
        add(0, 8'h00, 0, 0, 0, 8'h00, Z,     0, 0, 8'h00, Z,     0, W04, 0, WBEEF, 0, 0);

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_state", act_bundle(), 128'h0);
        @(posedge clock); #1 reset = 1'b1;

        // per-cycle vector table
        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clock); #1;
            i_req = vq[k].ir; i_addr = vq[k].ia; i_flush = vq[k].fl;
            d_req = vq[k].dr; d_we = vq[k].dw; d_addr = vq[k].da; d_wdata = vq[k].dd;
            @(negedge clock);
            check($sformatf("row%0d", k), act_bundle(), exp_bundle(vq[k]));
        end

        // reset in cycle 2 of a load from 0x20
        @(posedge clock); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
        @(posedge clock); #1;
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1 reset = 1'b1; d_req = 1'b0;
        @(negedge clock);
        check("reset_mid_load_outputs", {1'b0, m_en, m_we, m_addr, m_wdata, i_ready, i_rdata, d_ready, d_rdata},
              {1'b0, 1'b0, 1'b0, 8'h00, Z, 1'b0, Z, 1'b0, Z});
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (d_ready || i_ready || m_en || d_rdata != Z) bad = 1'b1;
        end
        check("reset_late_rdata_ignored", {127'h0, bad}, 128'h0);
        // new fetch after the abandoned load is granted from IDLE
        @(posedge clock); #1 i_req = 1'b1; i_addr = 8'h04;
        @(posedge clock); #1;
        @(negedge clock);
        check("post_reset_grant", {118'h0, m_en, m_addr, i_ready}, {118'h0, 1'b1, 8'h04, 1'b0});
        got_ready = 1'b0;
        for (int c = 0; c < 8 && !got_ready; c++) begin
            @(negedge clock);
            if (i_ready) begin
                got_ready = 1'b1;
                check("post_reset_fetch_data", {96'h0, i_rdata}, {96'h0, W04});
            end
        end
        if (!got_ready) begin
            tests++; fails++;
            $display("FAIL post_reset_fetch_timeout: got no i_ready expected i_ready within 8 cycles");
        end
        @(posedge clock); #1 i_req = 1'b0;

        // LAT=1: load readies in cycle 3
        @(posedge clock); #1 d_req1 = 1'b1; d_addr1 = 8'h20;
        rdy_hist = 5'b0; rdata_c3 = Z;
        @(negedge clock); rdy_hist[0] = d_ready1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            if (c == 4) d_req1 = 1'b0;
            @(negedge clock);
            rdy_hist[c] = d_ready1;
            if (c == 3) rdata_c3 = d_rdata1;
        end
        check("lat1_load_ready_cycle", {123'h0, rdy_hist}, {123'h0, 5'b01000});
        check("lat1_load_data", {96'h0, rdata_c3}, {96'h0, 32'hC0DE0020});

        // LAT=1: continuous fetch stream, PC advances on each i_ready
        exp_addr = 8'h40; stop = 1'b0; prev_rdy = 1'b0; en_cnt = 0; rdy_cnt = 0; bad = 1'b0;
        for (int c = 0; c < 32; c++) begin
            @(posedge clock); #1 i_req1 = !stop; i_addr1 = exp_addr;
            @(negedge clock);
            if (m_en1) en_cnt++;
            if (i_ready1) begin
                rdy_cnt++;
                check($sformatf("lat1_fetch_%0d", rdy_cnt), {96'h0, i_rdata1}, {96'h0, 24'hC0DE00, exp_addr});
                if (prev_rdy) bad = 1'b1;
                exp_addr = exp_addr + 8'h01;
                if (c >= 20) stop = 1'b1;
            end
            prev_rdy = i_ready1;
        end
        i_req1 = 1'b0;
        check("lat1_no_back_to_back_ready", {127'h0, bad}, 128'h0);
        check("lat1_ready_per_access", {96'h0, 32'(en_cnt)}, {96'h0, 32'(rdy_cnt)});
        check("lat1_min_throughput", {127'h0, (rdy_cnt >= 5)}, {127'h0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
